// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared CPU/ISA codes and widths used by the execute stage.
// Revision 1.0
`default_nettype none

package ex_stage_pkg;

   localparam int WORD_W      = 32;
   localparam int WORD_ADDR_W = 30;
   localparam int REG_ADDR_W  = 5;

   localparam logic [3:0] ALU_OP_NOP  = 4'd0;
   localparam logic [3:0] ALU_OP_AND  = 4'd1;
   localparam logic [3:0] ALU_OP_OR   = 4'd2;
   localparam logic [3:0] ALU_OP_XOR  = 4'd3;
   localparam logic [3:0] ALU_OP_ADDS = 4'd4;
   localparam logic [3:0] ALU_OP_ADDU = 4'd5;
   localparam logic [3:0] ALU_OP_SUBS = 4'd6;
   localparam logic [3:0] ALU_OP_SUBU = 4'd7;
   localparam logic [3:0] ALU_OP_SHRL = 4'd8;
   localparam logic [3:0] ALU_OP_SHLL = 4'd9;
   localparam logic [3:0] ALU_OP_MULU = 4'd10;

   localparam logic [1:0] MEM_OP_NOP = 2'd0;
   localparam logic [1:0] MEM_OP_LDW = 2'd1;
   localparam logic [1:0] MEM_OP_STW = 2'd2;

   localparam logic [1:0] CTRL_OP_NOP  = 2'd0;
   localparam logic [1:0] CTRL_OP_WRCR = 2'd1;
   localparam logic [1:0] CTRL_OP_EXRT = 2'd2;

   localparam logic [2:0] ISA_EXP_NO_EXP     = 3'h0;
   localparam logic [2:0] ISA_EXP_EXT_INT    = 3'h1;
   localparam logic [2:0] ISA_EXP_UNDEF_INSN = 3'h2;
   localparam logic [2:0] ISA_EXP_OVERFLOW   = 3'h3;
   localparam logic [2:0] ISA_EXP_MISS_ALIGN = 3'h4;
   localparam logic [2:0] ISA_EXP_TRAP       = 3'h5;
   localparam logic [2:0] ISA_EXP_PRV_VIO    = 3'h6;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_MUL  = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_e;

endpackage

`default_nettype wire

// File: rtl/ex_mul.sv
// ex_mul: iterative 32-cycle shift-add multiplier, low 32 bits of the product.
// Revision 1.0
`default_nettype none

module ex_mul
   import ex_stage_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   input  logic        hold,
   input  logic [31:0] mcand_in,
   input  logic [31:0] mplier_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] product
);

   mul_state_e  state_q, state_d;
   logic [31:0] mcand_q, mcand_d;
   logic [31:0] mplier_q, mplier_d;
   logic [31:0] acc_q, acc_d;
   logic [4:0]  count_q, count_d;

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      count_d  = count_q;
      case (state_q)
         MUL_IDLE: begin
            if (start) begin
               state_d  = MUL_MUL;
               mcand_d  = mcand_in;
               mplier_d = mplier_in;
               acc_d    = '0;
               count_d  = '0;
            end
         end
         MUL_MUL: begin
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + 5'd1;
            if (count_q == 5'd31) begin
               state_d = MUL_DONE;
            end
         end
         MUL_DONE: begin
            // Product is held until the EX/MEM register is free to take it.
            if (!hold) begin
               state_d = MUL_IDLE;
            end
         end
         default: state_d = MUL_IDLE;
      endcase
      if (abort) begin
         state_d = MUL_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= MUL_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         count_q  <= count_d;
      end
   end

   assign busy    = (state_q == MUL_MUL);
   assign done    = (state_q == MUL_DONE);
   assign product = acc_q;

endmodule

`default_nettype wire

// File: rtl/ex_stage.sv
// ex_stage: execute stage - ALU, overflow detection, MULU sequencing, EX/MEM register.
// Revision 1.0
`default_nettype none

module ex_stage
   import ex_stage_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [29:0] id_pc,
   input  logic        id_en,
   input  logic [3:0]  id_alu_op,
   input  logic [31:0] id_alu_in_0,
   input  logic [31:0] id_alu_in_1,
   input  logic        id_br_flag,
   input  logic [1:0]  id_mem_op,
   input  logic [31:0] id_mem_wr_data,
   input  logic [1:0]  id_ctrl_op,
   input  logic [4:0]  id_dst_addr,
   input  logic        id_gpr_we_,
   input  logic [2:0]  id_exp_code,
   input  logic        stall,
   input  logic        flush,
   output logic [31:0] fwd_data,
   output logic        ex_busy,
   output logic [29:0] ex_pc,
   output logic        ex_en,
   output logic        ex_br_flag,
   output logic [1:0]  ex_mem_op,
   output logic [31:0] ex_mem_wr_data,
   output logic [1:0]  ex_ctrl_op,
   output logic [4:0]  ex_dst_addr,
   output logic        ex_gpr_we_,
   output logic [2:0]  ex_exp_code,
   output logic [31:0] ex_out
);

   logic        mul_launch, mul_busy, mul_done;
   logic [31:0] mul_product;
   logic [31:0] alu_out;
   logic        overflow;

   // Reset gates the launch so ex_busy is low for the whole reset cycle.
   assign mul_launch = reset && id_en && (id_alu_op == ALU_OP_MULU) && !flush;
   assign ex_busy    = (!mul_busy && !mul_done && mul_launch) || mul_busy;

   ex_mul u_mul (
      .clk       (clk),
      .reset     (reset),
      .start     (mul_launch),
      .abort     (flush),
      .hold      (stall),
      .mcand_in  (id_alu_in_0),
      .mplier_in (id_alu_in_1),
      .busy      (mul_busy),
      .done      (mul_done),
      .product   (mul_product)
   );

   always_comb begin
      alu_out = '0;
      case (id_alu_op)
         ALU_OP_AND:  alu_out = id_alu_in_0 & id_alu_in_1;
         ALU_OP_OR:   alu_out = id_alu_in_0 | id_alu_in_1;
         ALU_OP_XOR:  alu_out = id_alu_in_0 ^ id_alu_in_1;
         ALU_OP_ADDS,
         ALU_OP_ADDU: alu_out = id_alu_in_0 + id_alu_in_1;
         ALU_OP_SUBS,
         ALU_OP_SUBU: alu_out = id_alu_in_0 - id_alu_in_1;
         ALU_OP_SHRL: alu_out = id_alu_in_0 >> id_alu_in_1[4:0];
         ALU_OP_SHLL: alu_out = id_alu_in_0 << id_alu_in_1[4:0];
         ALU_OP_MULU: alu_out = mul_product;
         default:     alu_out = '0;
      endcase
   end

   assign fwd_data = alu_out;

   always_comb begin
      overflow = 1'b0;
      if (id_en && (id_alu_op == ALU_OP_ADDS)) begin
         overflow = (id_alu_in_0[31] == id_alu_in_1[31]) && (alu_out[31] != id_alu_in_0[31]);
      end else if (id_en && (id_alu_op == ALU_OP_SUBS)) begin
         overflow = (id_alu_in_0[31] != id_alu_in_1[31]) && (alu_out[31] != id_alu_in_0[31]);
      end
   end

   logic [29:0] pc_q, pc_d;
   logic        en_q, en_d, br_flag_q, br_flag_d, gpr_we_q, gpr_we_d;
   logic [1:0]  mem_op_q, mem_op_d, ctrl_op_q, ctrl_op_d;
   logic [31:0] mem_wr_data_q, mem_wr_data_d, out_q, out_d;
   logic [4:0]  dst_addr_q, dst_addr_d;
   logic [2:0]  exp_code_q, exp_code_d;

   always_comb begin
      pc_d          = '0;
      en_d          = 1'b0;
      br_flag_d     = 1'b0;
      mem_op_d      = MEM_OP_NOP;
      mem_wr_data_d = '0;
      ctrl_op_d     = CTRL_OP_NOP;
      dst_addr_d    = '0;
      gpr_we_d      = 1'b1;
      exp_code_d    = ISA_EXP_NO_EXP;
      out_d         = '0;
      if (stall) begin
         pc_d          = pc_q;
         en_d          = en_q;
         br_flag_d     = br_flag_q;
         mem_op_d      = mem_op_q;
         mem_wr_data_d = mem_wr_data_q;
         ctrl_op_d     = ctrl_op_q;
         dst_addr_d    = dst_addr_q;
         gpr_we_d      = gpr_we_q;
         exp_code_d    = exp_code_q;
         out_d         = out_q;
      end else if (!flush && !ex_busy) begin
         pc_d          = id_pc;
         en_d          = id_en;
         br_flag_d     = id_br_flag;
         mem_op_d      = overflow ? MEM_OP_NOP : id_mem_op;
         mem_wr_data_d = id_mem_wr_data;
         ctrl_op_d     = id_ctrl_op;
         dst_addr_d    = id_dst_addr;
         gpr_we_d      = overflow ? 1'b1 : id_gpr_we_;
         exp_code_d    = overflow ? ISA_EXP_OVERFLOW : id_exp_code;
         out_d         = alu_out;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q          <= '0;
         en_q          <= 1'b0;
         br_flag_q     <= 1'b0;
         mem_op_q      <= MEM_OP_NOP;
         mem_wr_data_q <= '0;
         ctrl_op_q     <= CTRL_OP_NOP;
         dst_addr_q    <= '0;
         gpr_we_q      <= 1'b1;
         exp_code_q    <= ISA_EXP_NO_EXP;
         out_q         <= '0;
      end else begin
         pc_q          <= pc_d;
         en_q          <= en_d;
         br_flag_q     <= br_flag_d;
         mem_op_q      <= mem_op_d;
         mem_wr_data_q <= mem_wr_data_d;
         ctrl_op_q     <= ctrl_op_d;
         dst_addr_q    <= dst_addr_d;
         gpr_we_q      <= gpr_we_d;
         exp_code_q    <= exp_code_d;
         out_q         <= out_d;
      end
   end

   assign ex_pc          = pc_q;
   assign ex_en          = en_q;
   assign ex_br_flag     = br_flag_q;
   assign ex_mem_op      = mem_op_q;
   assign ex_mem_wr_data = mem_wr_data_q;
   assign ex_ctrl_op     = ctrl_op_q;
   assign ex_dst_addr    = dst_addr_q;
   assign ex_gpr_we_     = gpr_we_q;
   assign ex_exp_code    = exp_code_q;
   assign ex_out         = out_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed-vector bench for the execute stage.
`default_nettype none

module tb_ex_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [29:0] id_pc;
   logic        id_en;
   logic [3:0]  id_alu_op;
   logic [31:0] id_alu_in_0, id_alu_in_1;
   logic        id_br_flag;
   logic [1:0]  id_mem_op;
   logic [31:0] id_mem_wr_data;
   logic [1:0]  id_ctrl_op;
   logic [4:0]  id_dst_addr;
   logic        id_gpr_we_;
   logic [2:0]  id_exp_code;
   logic        stall, flush;
   logic [31:0] fwd_data;
   logic        ex_busy;
   logic [29:0] ex_pc;
   logic        ex_en, ex_br_flag;
   logic [1:0]  ex_mem_op, ex_ctrl_op;
   logic [31:0] ex_mem_wr_data, ex_out;
   logic [4:0]  ex_dst_addr;
   logic        ex_gpr_we_;
   logic [2:0]  ex_exp_code;

   int n_checks = 0;
   int n_pass   = 0;

   ex_stage dut (
      .clk(clk), .reset(reset),
      .id_pc(id_pc), .id_en(id_en), .id_alu_op(id_alu_op),
      .id_alu_in_0(id_alu_in_0), .id_alu_in_1(id_alu_in_1),
      .id_br_flag(id_br_flag), .id_mem_op(id_mem_op), .id_mem_wr_data(id_mem_wr_data),
      .id_ctrl_op(id_ctrl_op), .id_dst_addr(id_dst_addr), .id_gpr_we_(id_gpr_we_),
      .id_exp_code(id_exp_code), .stall(stall), .flush(flush),
      .fwd_data(fwd_data), .ex_busy(ex_busy),
      .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag), .ex_mem_op(ex_mem_op),
      .ex_mem_wr_data(ex_mem_wr_data), .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
      .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code), .ex_out(ex_out)
   );

   always #5 clk = ~clk;

   localparam logic [3:0]  T_OP [0:8] = '{4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9, 4'd6, 4'd0, 4'd4};
   localparam logic [31:0] T_A  [0:8] = '{32'hF0F0_1234, 32'hF0F0_1234, 32'hF0F0_1234, 32'h3,
                                          32'h8000_0010, 32'h1, 32'h5, 32'h1234, 32'hFFFF_FFFF};
   localparam logic [31:0] T_B  [0:8] = '{32'h0FF0_FF00, 32'h0FF0_FF00, 32'h0FF0_FF00, 32'h5,
                                          32'h4, 32'h3F, 32'h7, 32'h5, 32'h1};
   localparam logic [31:0] T_R  [0:8] = '{32'h00F0_1200, 32'hFFF0_FF34, 32'hFF00_ED34, 32'hFFFF_FFFE,
                                          32'h0800_0001, 32'h8000_0000, 32'hFFFF_FFFE, 32'h0, 32'h0};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_bubble();
      id_pc = '0; id_en = 1'b0; id_alu_op = 4'd0; id_alu_in_0 = '0; id_alu_in_1 = '0;
      id_br_flag = 1'b0; id_mem_op = 2'd0; id_mem_wr_data = '0; id_ctrl_op = 2'd0;
      id_dst_addr = '0; id_gpr_we_ = 1'b1; id_exp_code = 3'd0;
   endtask

   task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      set_bubble();
      id_en = 1'b1; id_alu_op = op; id_alu_in_0 = a; id_alu_in_1 = b; id_gpr_we_ = 1'b0;
      id_dst_addr = 5'd3;
   endtask

   task automatic test_reset();
      reset = 1'b0; stall = 1'b0; flush = 1'b0;
      set_bubble();
      step(); step();
      n_checks++; if (ex_en !== 1'b0) $display("FAIL reset_en: got %b exp 0", ex_en); else n_pass++;
      n_checks++; if (ex_gpr_we_ !== 1'b1) $display("FAIL reset_we: got %b exp 1", ex_gpr_we_); else n_pass++;
      n_checks++; if (ex_out !== 32'h0 || ex_pc !== 30'h0 || ex_mem_op !== 2'd0 || ex_exp_code !== 3'd0)
         $display("FAIL reset_vals: got out %h pc %h mem %h exp %h, exp all 0", ex_out, ex_pc, ex_mem_op, ex_exp_code);
      else n_pass++;
      n_checks++; if (ex_busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", ex_busy); else n_pass++;
      reset = 1'b1;
   endtask

   task automatic test_addu();
      set_op(4'd5, 32'h5, 32'h3);
      id_pc = 30'h0000_0100; id_dst_addr = 5'd7; id_br_flag = 1'b1; id_ctrl_op = 2'd1;
      id_mem_wr_data = 32'hCAFE_F00D; id_mem_op = 2'd1;
      #1;
      n_checks++; if (fwd_data !== 32'h8) $display("FAIL addu_fwd: got %h exp 00000008", fwd_data); else n_pass++;
      step();
      n_checks++; if (ex_out !== 32'h8 || ex_en !== 1'b1 || ex_exp_code !== 3'd0 || ex_gpr_we_ !== 1'b0)
         $display("FAIL addu_reg: got out %h en %b exp %h we %b, exp 8 1 0 0", ex_out, ex_en, ex_exp_code, ex_gpr_we_);
      else n_pass++;
      n_checks++; if (ex_pc !== 30'h100 || ex_dst_addr !== 5'd7 || ex_br_flag !== 1'b1 || ex_ctrl_op !== 2'd1
                      || ex_mem_wr_data !== 32'hCAFE_F00D || ex_mem_op !== 2'd1)
         $display("FAIL addu_pass: got pc %h dst %h br %b ctrl %h wd %h mem %h", ex_pc, ex_dst_addr,
                  ex_br_flag, ex_ctrl_op, ex_mem_wr_data, ex_mem_op);
      else n_pass++;
   endtask

   task automatic test_alu_table();
      for (int i = 0; i < 9; i++) begin
         set_op(T_OP[i], T_A[i], T_B[i]);
         #1;
         n_checks++; if (fwd_data !== T_R[i]) $display("FAIL alu_fwd[%0d]: got %h exp %h", i, fwd_data, T_R[i]); else n_pass++;
         step();
         n_checks++; if (ex_out !== T_R[i] || ex_exp_code !== 3'd0 || ex_en !== 1'b1)
            $display("FAIL alu_reg[%0d]: got out %h exp %h en %b, exp out %h code 0 en 1", i, ex_out, ex_exp_code, ex_en, T_R[i]);
         else n_pass++;
      end
   endtask

   task automatic test_overflow();
      set_op(4'd4, 32'h7FFF_FFFF, 32'h1);
      id_mem_op = 2'd2;
      step();
      n_checks++; if (ex_exp_code !== 3'd3 || ex_gpr_we_ !== 1'b1 || ex_mem_op !== 2'd0 || ex_out !== 32'h8000_0000)
         $display("FAIL adds_ovf: got code %h we %b mem %h out %h, exp 3 1 0 80000000", ex_exp_code, ex_gpr_we_, ex_mem_op, ex_out);
      else n_pass++;
      set_op(4'd6, 32'h8000_0000, 32'h1);
      step();
      n_checks++; if (ex_exp_code !== 3'd3 || ex_gpr_we_ !== 1'b1 || ex_out !== 32'h7FFF_FFFF)
         $display("FAIL subs_ovf: got code %h we %b out %h, exp 3 1 7fffffff", ex_exp_code, ex_gpr_we_, ex_out);
      else n_pass++;
      set_op(4'd4, 32'h7FFF_FFFF, 32'h1);
      id_en = 1'b0; id_mem_op = 2'd2;
      step();
      n_checks++; if (ex_exp_code !== 3'd0 || ex_gpr_we_ !== 1'b0 || ex_mem_op !== 2'd2 || ex_en !== 1'b0)
         $display("FAIL ovf_noen: got code %h we %b mem %h en %b, exp 0 0 2 0", ex_exp_code, ex_gpr_we_, ex_mem_op, ex_en);
      else n_pass++;
   endtask

   task automatic test_mulu();
      int busy_cycles = 0;
      bit en_bad = 1'b0;
      set_op(4'd10, 32'h0001_0003, 32'h5);
      #1;
      while (ex_busy === 1'b1 && busy_cycles < 100) begin
         busy_cycles++;
         step();
         if (ex_en !== 1'b0) en_bad = 1'b1;
      end
      n_checks++; if (busy_cycles != 33) $display("FAIL mulu_busy_len: got %0d exp 33", busy_cycles); else n_pass++;
      n_checks++; if (en_bad) $display("FAIL mulu_en_low: got ex_en=1 while busy, exp 0"); else n_pass++;
      n_checks++; if (fwd_data !== 32'h0005_000F) $display("FAIL mulu_fwd: got %h exp 0005000f", fwd_data); else n_pass++;
      step();
      n_checks++; if (ex_out !== 32'h0005_000F || ex_en !== 1'b1)
         $display("FAIL mulu_reg: got out %h en %b, exp 0005000f 1", ex_out, ex_en);
      else n_pass++;
      set_bubble();
      #1;
      n_checks++; if (ex_busy !== 1'b0) $display("FAIL mulu_idle: got busy %b exp 0", ex_busy); else n_pass++;
   endtask

   task automatic test_flush();
      set_op(4'd10, 32'h7, 32'h9);
      for (int i = 0; i < 11; i++) step();
      n_checks++; if (ex_busy !== 1'b1) $display("FAIL flush_pre_busy: got %b exp 1", ex_busy); else n_pass++;
      flush = 1'b1;
      step();
      flush = 1'b0;
      set_bubble();
      #1;
      n_checks++; if (ex_busy !== 1'b0 || ex_en !== 1'b0 || ex_gpr_we_ !== 1'b1)
         $display("FAIL flush_abort: got busy %b en %b we %b, exp 0 0 1", ex_busy, ex_en, ex_gpr_we_);
      else n_pass++;
      set_op(4'd5, 32'h2, 32'h2);
      #1;
      n_checks++; if (fwd_data !== 32'h4 || ex_busy !== 1'b0)
         $display("FAIL flush_next_fwd: got fwd %h busy %b, exp 4 0", fwd_data, ex_busy);
      else n_pass++;
      step();
      n_checks++; if (ex_out !== 32'h4 || ex_en !== 1'b1) $display("FAIL flush_next_reg: got %h en %b, exp 4 1", ex_out, ex_en); else n_pass++;
      set_op(4'd5, 32'h9, 32'h1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      n_checks++; if (ex_en !== 1'b0 || ex_out !== 32'h0) $display("FAIL flush_alu: got en %b out %h, exp 0 0", ex_en, ex_out); else n_pass++;
   endtask

   task automatic test_stall();
      bit hold_bad = 1'b0;
      set_op(4'd10, 32'h1234, 32'h10);
      for (int i = 0; i < 32; i++) step();
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         if (ex_en !== 1'b0 || ex_out !== 32'h0) hold_bad = 1'b1;
      end
      n_checks++; if (hold_bad) $display("FAIL stall_hold: got ex_* changed under stall (out %h), exp held 0", ex_out); else n_pass++;
      n_checks++; if (ex_busy !== 1'b0 || fwd_data !== 32'h0001_2340)
         $display("FAIL stall_done: got busy %b fwd %h, exp 0 00012340", ex_busy, fwd_data);
      else n_pass++;
      stall = 1'b0;
      step();
      n_checks++; if (ex_out !== 32'h0001_2340 || ex_en !== 1'b1)
         $display("FAIL stall_capture: got out %h en %b, exp 00012340 1", ex_out, ex_en);
      else n_pass++;
      set_bubble();
   endtask

   task automatic test_bubble_mulu();
      set_op(4'd10, 32'h3, 32'h3);
      id_en = 1'b0;
      #1;
      n_checks++; if (ex_busy !== 1'b0) $display("FAIL bubble_mulu: got busy %b exp 0", ex_busy); else n_pass++;
      step();
      n_checks++; if (ex_busy !== 1'b0 || ex_en !== 1'b0) $display("FAIL bubble_mulu_next: got busy %b en %b, exp 0 0", ex_busy, ex_en); else n_pass++;
   endtask

   task automatic test_reset_mid();
      set_op(4'd10, 32'h3, 32'h3);
      for (int i = 0; i < 5; i++) step();
      reset = 1'b0;
      step();
      n_checks++; if (ex_busy !== 1'b0 || ex_en !== 1'b0 || ex_out !== 32'h0 || ex_gpr_we_ !== 1'b1 || ex_exp_code !== 3'd0)
         $display("FAIL rst_mul: got busy %b en %b out %h we %b code %h, exp 0 0 0 1 0", ex_busy, ex_en, ex_out, ex_gpr_we_, ex_exp_code);
      else n_pass++;
      set_op(4'd5, 32'h1, 32'h1);
      step();
      n_checks++; if (ex_en !== 1'b0 || ex_out !== 32'h0 || ex_dst_addr !== 5'd0)
         $display("FAIL rst_alu: got en %b out %h dst %h, exp 0 0 0", ex_en, ex_out, ex_dst_addr);
      else n_pass++;
      reset = 1'b1;
      set_bubble();
      #1;
      n_checks++; if (ex_busy !== 1'b0) $display("FAIL rst_idle: got busy %b exp 0", ex_busy); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_addu();
      test_alu_table();
      test_overflow();
      test_mulu();
      test_flush();
      test_stall();
      test_bubble_mulu();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, exp finish before 200000");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
